// File: rtl/line_window_buf_if.sv
// line_window_buf_if: raster pixel input and window column output bundle
interface line_window_buf_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 50,
  parameter int ROWS   = 3
);
  localparam int X_W = $clog2(IMG_W) < 1 ? 1 : $clog2(IMG_W);
  logic                   sof;
  logic                   in_vld;
  logic [DATA_W-1:0]      in_data;
  logic                   out_vld;
  logic [ROWS*DATA_W-1:0] out_col;
  logic [X_W-1:0]         out_x;
  logic                   out_eol;
  modport master (
    output sof, in_vld, in_data,
    input  out_vld, out_col, out_x, out_eol
  );
  modport slave (
    input  sof, in_vld, in_data,
    output out_vld, out_col, out_x, out_eol
  );
endinterface

// File: rtl/line_window_buf.sv
// line_window_buf: ROWS-1 line memories producing a vertical pixel column per input beat
module line_window_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 50,
  parameter int ROWS   = 3
) (
  input logic               sclk,
  input logic               rst,
  line_window_buf_if.slave  s
);
  localparam int X_W = $clog2(IMG_W) < 1 ? 1 : $clog2(IMG_W);
  localparam int Y_W = $clog2(ROWS);
  logic [DATA_W-1:0]      mem [ROWS-1][IMG_W];
  logic [X_W-1:0]         x, xe;
  logic [Y_W-1:0]         y, ye;
  logic [ROWS*DATA_W-1:0] col;
  logic                   last;
  // sof forces the current beat to x=0,y=0 before addressing and counting
  always_comb begin
    xe = s.sof ? '0 : x;
    ye = s.sof ? '0 : y;
    last = xe == X_W'(IMG_W - 1);
    col = (ROWS*DATA_W)'(s.in_data);
    for (int i = 0; i < ROWS - 1; i++) col[(i+1)*DATA_W +: DATA_W] = mem[i][xe];
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      s.out_vld <= 1'b0;
      s.out_col <= '0;
      s.out_x   <= '0;
      s.out_eol <= 1'b0;
    end else begin
      s.out_vld <= s.in_vld && ye == Y_W'(ROWS - 1);
      if (s.in_vld) begin
        x         <= last ? '0 : xe + 1'b1;
        y         <= (last && ye != Y_W'(ROWS - 1)) ? ye + 1'b1 : ye;
        s.out_col <= col;
        s.out_x   <= xe;
        s.out_eol <= last;
      end
    end
  end
  // each line memory passes its old pixel down to the next older line
  always_ff @(posedge sclk) begin
    if (!rst && s.in_vld) begin
      mem[0][xe] <= s.in_data;
      for (int i = 1; i < ROWS - 1; i++) mem[i][xe] <= mem[i-1][xe];
    end
  end
endmodule

// File: tb/tb_line_window_buf.sv
// tb_line_window_buf: directed checks of fill, gaps, sof resync, reset and a 5-row variant
module tb_line_window_buf;
  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 sclk = ~sclk;
  line_window_buf_if #(.DATA_W(8),  .IMG_W(4), .ROWS(3)) ia ();
  line_window_buf_if #(.DATA_W(10), .IMG_W(4), .ROWS(5)) ib ();
  line_window_buf #(.DATA_W(8),  .IMG_W(4), .ROWS(3)) ua (.sclk(sclk), .rst(rst), .s(ia.slave));
  line_window_buf #(.DATA_W(10), .IMG_W(4), .ROWS(5)) ub (.sclk(sclk), .rst(rst), .s(ib.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step_a(input logic v, input logic f, input logic [7:0] d);
    ia.in_vld = v;
    ia.sof = f;
    ia.in_data = d;
    @(posedge sclk);
    #1;
    ia.in_vld = 1'b0;
    ia.sof = 1'b0;
  endtask
  task automatic step_b(input logic v, input logic [9:0] d);
    ib.in_vld = v;
    ib.in_data = d;
    @(posedge sclk);
    #1;
    ib.in_vld = 1'b0;
  endtask
  // p: 1-based pixel index since frame start, d: pixel value, idle: checking a gap cycle
  task automatic check_a(input string tag, input int p, input int d, input logic idle);
    logic [7:0] d0, d1, d2;
    d0 = 8'(d);
    d1 = 8'(d - 4);
    d2 = 8'(d - 8);
    check({tag, "_vld"}, 64'(ia.out_vld), 64'(!idle && p >= 9));
    check({tag, "_x"}, 64'(ia.out_x), 64'((p - 1) % 4));
    check({tag, "_eol"}, 64'(ia.out_eol), 64'(p % 4 == 0));
    if (p >= 9) check({tag, "_col"}, 64'(ia.out_col), 64'({d2, d1, d0}));
  endtask
  task automatic check_b(input int p);
    logic [9:0] c [5];
    for (int k = 0; k < 5; k++) c[k] = 10'(p - 4 * k);
    check("p5_vld", 64'(ib.out_vld), 64'(p >= 17));
    check("p5_eol", 64'(ib.out_eol), 64'(p % 4 == 0));
    if (p >= 17) check("p5_col", 64'(ib.out_col), 64'({c[4], c[3], c[2], c[1], c[0]}));
  endtask
  initial begin
    ia.in_vld = 1'b0; ia.sof = 1'b0; ia.in_data = '0;
    ib.in_vld = 1'b0; ib.sof = 1'b0; ib.in_data = '0;
    repeat (2) @(posedge sclk);
    #1;
    check("rst_vld", 64'(ia.out_vld), 64'd0);
    check("rst_col", 64'(ia.out_col), 64'd0);
    check("rst_x", 64'(ia.out_x), 64'd0);
    check("rst_eol", 64'(ia.out_eol), 64'd0);
    check("rst_b_col", 64'(ib.out_col), 64'd0);
    rst = 1'b0;
    for (int p = 1; p <= 13; p++) begin
      step_a(1'b1, p == 1, 8'(p));
      check_a("fill", p, p, 1'b0);
    end
    check("fill13_col", 64'(ia.out_col), 64'h05090D);
    for (int p = 1; p <= 12; p++) begin
      step_a(1'b1, p == 1, 8'(p));
      check_a("gap", p, p, 1'b0);
      step_a(1'b0, 1'b0, 8'hEE);
      check_a("gap_idle", p, p, 1'b1);
    end
    for (int p = 1; p <= 6; p++) step_a(1'b1, p == 1, 8'(p));
    for (int i = 0; i < 12; i++) begin
      step_a(1'b1, i == 0, 8'(100 + i));
      check_a("sof", i + 1, 100 + i, 1'b0);
      if (i == 8) check("sof108_col", 64'(ia.out_col), 64'h64686C);
    end
    step_a(1'b0, 1'b1, 8'h55);
    check("sof_novld_vld", 64'(ia.out_vld), 64'd0);
    for (int p = 1; p <= 6; p++) step_a(1'b1, p == 1, 8'(p));
    rst = 1'b1;
    step_a(1'b1, 1'b1, 8'd77);
    check("mid_rst_vld", 64'(ia.out_vld), 64'd0);
    check("mid_rst_col", 64'(ia.out_col), 64'd0);
    check("mid_rst_x", 64'(ia.out_x), 64'd0);
    check("mid_rst_eol", 64'(ia.out_eol), 64'd0);
    rst = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      step_a(1'b1, 1'b0, 8'(p));
      check_a("after_rst", p, p, 1'b0);
    end
    check("after_rst9_col", 64'(ia.out_col), 64'h010509);
    rst = 1'b1;
    step_b(1'b0, 10'd0);
    rst = 1'b0;
    for (int p = 1; p <= 20; p++) begin
      step_b(1'b1, 10'(p));
      check_b(p);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
